// File: rtl/hamming_ser_enc.sv
// hamming_ser_enc
//    Serial Hamming encoder. Data bits arrive one per accepted cycle. They are
//    placed at the non-power-of-two positions (3,5,6,7,9,...) of an N-bit
//    codeword buffer. When the buffer holds a full word, parity is computed in
//    one cycle, and then the codeword is shifted out serially with a
//    valid/ready handshake.
//
//    Parameter
//       R           parity-bit count (3..6); N = 2**R, K = N-R-1 data bits
//
//    Ports
//       clk         rising-edge clock
//       rst         synchronous active-high reset
//       datain      serial data bit
//       din_valid   datain valid this cycle
//       din_ready   encoder accepts datain this cycle
//       dataout     serial codeword bit
//       dout_valid  dataout valid
//       dout_ready  sink takes dataout this cycle
//       dout_last   dataout is the final codeword bit
//
//    Build option
//       HAMMING_EXT_PARITY_EN  defined: position 0 carries overall (SECDED)
//                              parity and N bits are emitted from index 0.
//                              undefined: position 0 is unused and N-1 bits
//                              are emitted from index 1.
//
//    state   | meaning
//    --------+------------------------------------------------------------
//    COLLECT | accepting data bits into the buffer, din_ready=1
//    COMPUTE | one cycle: parity bits written into positions 2**i (and 0)
//    SHIFT   | codeword presented on dataout, index advances on dout_ready

module hamming_ser_enc #(
   parameter int R = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic datain,
   input  logic din_valid,
   output logic din_ready,
   output logic dataout,
   output logic dout_valid,
   input  logic dout_ready,
   output logic dout_last
);

   localparam int N  = 1 << R;
   localparam int K  = N - R - 1;
   localparam int CW = $clog2(N + 1);

   localparam logic [CW-1:0] ONE       = CW'(1);
   localparam logic [CW-1:0] FIRST_POS = CW'(3);
   localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
   localparam logic [CW-1:0] K_LAST    = CW'(K - 1);
`ifdef HAMMING_EXT_PARITY_EN
   localparam logic [CW-1:0] FIRST_IDX = CW'(0);
`else
   localparam logic [CW-1:0] FIRST_IDX = CW'(1);
`endif

   if (R < 3 || R > 6) begin : g_bad_r
      $error("hamming_ser_enc: R must be in 3..6");
   end

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      COMPUTE = 2'd1,
      SHIFT   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   dcnt_q;
   logic [CW-1:0]   wptr_q;
   logic [CW-1:0]   wptr_inc;
   logic [CW-1:0]   wptr_nxt;
   logic [CW-1:0]   oidx_q;
   logic [N-1:0]    mem_q;
   logic [N-1:0]    mem_cw;
   logic [R-1:0]    par_bits;
   logic            last_data;

   // Data positions: index >= 3 and not a power of two.
   function automatic logic is_data(input int j);
      return (j >= 3) && ((j & (j - 1)) != 0);
   endfunction

   // Next write position skips over power-of-two indices. Since positions
   // >= 4 never have two adjacent powers of two, one extra step suffices.
   always_comb begin
      wptr_inc = wptr_q + ONE;
      wptr_nxt = wptr_inc;
      if ((wptr_inc & (wptr_inc - ONE)) == '0) begin
         wptr_nxt = wptr_inc + ONE;
      end
   end

   assign last_data = (dcnt_q == K_LAST);

   // Parity is taken only over data positions. The buffer still holds the
   // previous word's parity bits, so those must not leak into the sum.
   always_comb begin
      par_bits = '0;
      for (int i = 0; i < R; i++) begin
         for (int j = 0; j < N; j++) begin
            if (is_data(j) && (((j >> i) & 1) == 1)) begin
               par_bits[i] = par_bits[i] ^ mem_q[j];
            end
         end
      end
   end

   always_comb begin
      mem_cw = mem_q;
      for (int i = 0; i < R; i++) begin
         mem_cw[1 << i] = par_bits[i];
      end
`ifdef HAMMING_EXT_PARITY_EN
      mem_cw[0] = ^mem_cw[N-1:1];
`else
      mem_cw[0] = 1'b0;
`endif
   end

   always_comb begin
      state_d    = state_q;
      din_ready  = 1'b0;
      dout_valid = 1'b0;
      dout_last  = 1'b0;
      dataout    = 1'b0;
      case (state_q)
         COLLECT: begin
            din_ready = 1'b1;
            if (din_valid && last_data) begin
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            state_d = SHIFT;
         end
         SHIFT: begin
            dout_valid = 1'b1;
            dataout    = mem_q[oidx_q[R-1:0]];
            dout_last  = (oidx_q == LAST_IDX);
            if (dout_ready && (oidx_q == LAST_IDX)) begin
               state_d = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= COLLECT;
         dcnt_q  <= '0;
         wptr_q  <= FIRST_POS;
         oidx_q  <= FIRST_IDX;
         mem_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            COLLECT: begin
               if (din_valid) begin
                  mem_q[wptr_q[R-1:0]] <= datain;
                  dcnt_q               <= dcnt_q + ONE;
                  wptr_q               <= last_data ? FIRST_POS : wptr_nxt;
               end
            end
            COMPUTE: begin
               mem_q  <= mem_cw;
               oidx_q <= FIRST_IDX;
            end
            SHIFT: begin
               if (dout_ready) begin
                  if (oidx_q == LAST_IDX) begin
                     oidx_q <= FIRST_IDX;
                     dcnt_q <= '0;
                     wptr_q <= FIRST_POS;
                  end else begin
                     oidx_q <= oidx_q + ONE;
                  end
               end
            end
            default: begin
               dcnt_q <= '0;
               oidx_q <= FIRST_IDX;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_ser_enc.sv
// tb_hamming_ser_enc
//    Scoreboard bench for hamming_ser_enc (R=4). Each word's expected codeword
//    is built by an independent model and queued when the word is sent. The
//    monitor pops and compares on every output handshake.
//    The model places parity so that the XOR of the indices of all set bits is
//    zero, which is the defining property of a Hamming codeword.

module tb_hamming_ser_enc;

   localparam int R = 4;
   localparam int N = 1 << R;
   localparam int K = N - R - 1;
`ifdef HAMMING_EXT_PARITY_EN
   localparam int FIRST = 0;
`else
   localparam int FIRST = 1;
`endif

   logic clk = 1'b0;
   logic rst, datain, din_valid, din_ready;
   logic dataout, dout_valid, dout_ready, dout_last;

   always #5 clk = ~clk;

   hamming_ser_enc #(.R(R)) dut (
      .clk        (clk),
      .rst        (rst),
      .datain     (datain),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dataout    (dataout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last)
   );

   int         checks = 0;
   int         errors = 0;
   int         hs_count = 0;
   logic [1:0] exp_q[$];
   logic       last_taken = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] encode(input logic [K-1:0] d);
      logic [N-1:0] cw = '0;
      int p = 3;
      int s = 0;
      for (int k = 0; k < K; k++) begin
         while ((p & (p - 1)) == 0) p++;
         cw[p] = d[k];
         if (d[k]) s = s ^ p;
         p++;
      end
      for (int i = 0; i < R; i++) begin
         cw[1 << i] = ((s >> i) & 1) == 1;
      end
`ifdef HAMMING_EXT_PARITY_EN
      cw[0] = ^cw[N-1:1];
`endif
      return cw;
   endfunction

   task automatic push_expected(input logic [N-1:0] cw);
      for (int i = FIRST; i < N; i++) begin
         exp_q.push_back({(i == N - 1), cw[i]});
      end
   endtask

   // Output monitor, sampling mid-cycle.
   always @(negedge clk) begin
      logic [1:0] e;
      if (rst) begin
         last_taken = 1'b0;
      end else begin
         if (last_taken) begin
            check("b2b_din_ready", din_ready, 1);
            last_taken = 1'b0;
         end
         if (!dout_valid) begin
            check("idle_last", dout_last, 0);
         end
         if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("dataout", dataout, e[0]);
               check("dout_last", dout_last, e[1]);
               if (dout_last) last_taken = 1'b1;
            end
            hs_count++;
         end
      end
   end

   task automatic send_bit(input logic b);
      int n = 0;
      datain    = b;
      din_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!din_ready && n < 200);
      if (!din_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [K-1:0] d, input bit keep_valid);
      push_expected(encode(d));
      for (int k = 0; k < K; k++) send_bit(d[k]);
      check("compute_valid", dout_valid, 0);
      check("compute_din_ready", din_ready, 0);
      if (!keep_valid) din_valid = 1'b0;
      @(posedge clk);
      #1;
      check("latency_valid", dout_valid, 1);
      check("shift_din_ready", din_ready, 0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [K-1:0] w;
      logic         held_d, held_l;
      int           target, n;

      rst        = 1'b1;
      datain     = 1'b0;
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_din_ready", din_ready, 1);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout_last", dout_last, 0);
      check("rst_dataout", dataout, 0);
      rst = 1'b0;

      // single 1 in the first data position, then all ones and all zeros
      send_word(11'b000_0000_0001, 0);
      wait_drain();
      send_word({K{1'b1}}, 0);
      wait_drain();
      send_word({K{1'b0}}, 0);
      wait_drain();

      for (int t = 0; t < 4; t++) begin
         w = K'($urandom);
         send_word(w, 0);
         wait_drain();
      end

      // sink stall mid-codeword; the sender pushes data that must be ignored
      target = hs_count + 4;
      send_word(11'b101_1001_0110, 0);
      n = 0;
      while (hs_count < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("stall_reach", (hs_count >= target), 1);
      @(posedge clk);
      #1;
      dout_ready = 1'b0;
      datain     = 1'b1;
      din_valid  = 1'b1;
      @(negedge clk);
      held_d = dataout;
      held_l = dout_last;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("stall_dataout", dataout, held_d);
         check("stall_last", dout_last, held_l);
         check("stall_valid", dout_valid, 1);
         check("stall_din_ready", din_ready, 0);
      end
      @(posedge clk);
      #1;
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      wait_drain();

      // partial word discarded by reset
      for (int k = 0; k < 6; k++) send_bit(1'b1);
      din_valid = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("prst_din_ready", din_ready, 1);
      check("prst_dout_valid", dout_valid, 0);
      send_word(11'b010_0110_1001, 0);
      wait_drain();

      // back-to-back words with din_valid held high
      send_word(11'b110_0011_1010, 1);
      send_word(11'b001_1100_0101, 1);
      din_valid = 1'b0;
      wait_drain();

      repeat (30) @(posedge clk);
      #1;
      check("final_idle_valid", dout_valid, 0);
      check("final_queue", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
